// File: rtl/turbo_ram_arb.sv
// Turbo RAM arbiter: grants one of NCH bus masters access to turbo RAM.
// Define TURBO_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module turbo_ram_arb #(
  parameter int NCH        = 2,
  parameter int AW         = 23,
  parameter int LAT        = 2,
  parameter int RST_STAGES = 8,
  localparam int GW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              c1,
  input  logic              c3,
  input  logic              clk7_en,
  input  logic              chip_idle,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH-1:0]    uds,
  input  logic [NCH-1:0]    lds,
  output logic              ph1,
  output logic              ph2,
  output logic              ram_cs,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_uds,
  output logic              ram_lds,
  output logic [NCH-1:0]    ready,
  output logic [GW-1:0]     grant_id,
  output logic              reset_sync
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [RST_STAGES-1:0] sync_q;
  logic [3:0]            cnt_q, cnt_d;
  logic [GW-1:0]         win;
  logic                  found;
  logic                  grant_ok;
  logic                  done;
  logic                  abort;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      reset_sync <= 1'b0;
      ph1        <= 1'b0;
      ph2        <= 1'b0;
    end else begin
      sync_q     <= {sync_q[RST_STAGES-2:0], 1'b1};
      reset_sync <= sync_q[RST_STAGES-1];
      ph1        <= reset_sync & c1 & c3;
      ph2        <= reset_sync & ~c1 & ~c3;
    end
  end

`ifdef TURBO_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] ptr_q;

  // Walk downwards so the candidate closest to the pointer wins.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (req[idx]) begin
        win   = GW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (grant_ok) begin
      ptr_q <= (int'(win) == NCH - 1) ? '0 : win + 1'b1;
    end
  end
`else
  always_comb begin
    win   = '0;
    found = |req;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) win = GW'(i);
    end
  end
`endif

  // No re-grant in the cycle the completion pulse is out.
  assign grant_ok = (state_q == IDLE) && ph2 && found &&
                    (ready == '0) && reset_sync;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_ok) begin
          state_d = ACCESS;
          cnt_d   = 4'(LAT);
        end
      end
      ACCESS: begin
        if (!req[grant_id]) begin
          abort   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0 && clk7_en && chip_idle) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ram_cs   <= 1'b0;
      ram_addr <= '0;
      ram_uds  <= 1'b0;
      ram_lds  <= 1'b0;
      ready    <= '0;
      grant_id <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= '0;
      if (grant_ok) begin
        ram_cs   <= 1'b1;
        ram_addr <= addr[int'(win)*AW +: AW];
        ram_uds  <= uds[win];
        ram_lds  <= lds[win];
        grant_id <= win;
      end
      if (done) begin
        ram_cs <= 1'b0;
        ready  <= NCH'(1) << grant_id;
      end
      if (abort) ram_cs <= 1'b0;
    end
  end

endmodule

// File: tb/tb_turbo_ram_arb.sv
// Bench for turbo_ram_arb: cycle model from the access rules plus
// directed scenarios with literal expectations.
module tb_turbo_ram_arb;
  localparam int NCH = 2;
  localparam int AW = 23;
  localparam int LAT = 2;
  localparam int RST_STAGES = 8;

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic c1 = 1'b0, c3 = 1'b0;
  logic clk7_en = 1'b0, chip_idle = 1'b1;
  logic [NCH-1:0] req = '0, uds = '0, lds = '0;
  logic [NCH*AW-1:0] addr = '0;
  logic ph1, ph2, ram_cs, ram_uds, ram_lds, reset_sync;
  logic [AW-1:0] ram_addr;
  logic [NCH-1:0] ready;
  logic [0:0] grant_id;

  int n_tests = 0;
  int n_fail = 0;

  turbo_ram_arb #(
    .NCH(NCH), .AW(AW), .LAT(LAT), .RST_STAGES(RST_STAGES)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .c1(c1), .c3(c3),
    .clk7_en(clk7_en), .chip_idle(chip_idle), .req(req),
    .addr(addr), .uds(uds), .lds(lds), .ph1(ph1), .ph2(ph2),
    .ram_cs(ram_cs), .ram_addr(ram_addr), .ram_uds(ram_uds),
    .ram_lds(ram_lds), .ready(ready), .grant_id(grant_id),
    .reset_sync(reset_sync)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Chipset phase pattern: ph1 slot, idle, ph2 slot, idle; 7 MHz enable once per 4.
  int cyc = 0;
  always @(posedge clk_sys) begin
    #2;
    cyc++;
    c1 = (cyc % 4 == 0) || (cyc % 4 == 1);
    c3 = (cyc % 4 == 0) || (cyc % 4 == 3);
    clk7_en = (cyc % 4 == 1);
  end

  function automatic int pick(logic [NCH-1:0] r, int start);
    for (int k = 0; k < NCH; k++)
      if (r[(start + k) % NCH]) return (start + k) % NCH;
    return 0;
  endfunction

  // Reference model: busy = chip select held, held = cycles spent in the access.
  int rel_edges, m_win, m_held, m_ptr;
  bit m_rs, m_ph1, m_ph2, m_busy, m_uds, m_lds, rs_old;
  logic [AW-1:0] m_addr;
  logic [NCH-1:0] m_ready, nxt_ready;

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rel_edges = 0; m_win = 0; m_held = 0; m_ptr = 0;
      m_rs = 0; m_ph1 = 0; m_ph2 = 0; m_busy = 0;
      m_uds = 0; m_lds = 0; m_addr = '0; m_ready = '0;
    end else begin
      rs_old = m_rs;
      nxt_ready = '0;
      if (m_busy) begin
        if (!req[m_win]) m_busy = 0;
        else if (m_held >= LAT && clk7_en && chip_idle) begin
          m_busy = 0;
          nxt_ready[m_win] = 1'b1;
        end else m_held++;
      end else if (rs_old && m_ph2 && req != '0 && m_ready == '0) begin
`ifdef TURBO_ARB_ROUND_ROBIN_EN
        m_win = pick(req, m_ptr);
        m_ptr = (m_win + 1) % NCH;
`else
        m_win = pick(req, 0);
`endif
        m_busy = 1; m_held = 0;
        m_addr = addr[m_win*AW +: AW];
        m_uds = uds[m_win]; m_lds = lds[m_win];
      end
      m_ready = nxt_ready;
      m_ph1 = rs_old && c1 && c3;
      m_ph2 = rs_old && !c1 && !c3;
      if (rel_edges < 1000) rel_edges++;
      m_rs = (rel_edges >= RST_STAGES + 1);
    end
  end

  always @(negedge clk_sys) begin
    chk("m_reset_sync", reset_sync, m_rs);
    chk("m_ph1", ph1, m_ph1);
    chk("m_ph2", ph2, m_ph2);
    chk("m_ram_cs", ram_cs, m_busy);
    chk("m_ready", ready, m_ready);
    chk("m_grant_id", grant_id, 64'(m_win));
    chk("m_ram_addr", ram_addr, m_addr);
    chk("m_ram_uds", ram_uds, m_uds);
    chk("m_ram_lds", ram_lds, m_lds);
    if (ready != '0) chk("onehot", $onehot(ready), 1);
  end

  task automatic wait_cs(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (ram_cs) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_cs: ram_cs 0 after 40 cycles, required 1");
    end
  endtask

  task automatic wait_ready(output bit ok, output int w);
    ok = 0; w = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_sys);
      w++;
      if (ready != '0) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_ready: ready 0 after 60 cycles, required pulse");
    end
  endtask

  initial begin
    bit ok, got;
    int w, att;
    int gids[4];

    repeat (3) @(posedge clk_sys);
    #2 reset = 1'b0;
    repeat (8) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rs_edge8", reset_sync, 0);
    chk("ph_pre_sync", {ph1, ph2}, 0);
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rs_edge9", reset_sync, 1);

    // Both channels requesting continuously.
    addr = {23'h0ABCDE, 23'h001234};
    uds = 2'b11; lds = 2'b10; chip_idle = 1'b1; req = 2'b11;
    for (int g = 0; g < 4; g++) begin
      wait_cs(ok);
      gids[g] = int'(grant_id);
      wait_ready(ok, w);
    end
    req = '0;
    for (int g = 0; g < 4; g++) begin
`ifdef TURBO_ARB_ROUND_ROBIN_EN
      chk($sformatf("C_gid%0d", g), gids[g], g % 2);
`else
      chk($sformatf("C_gid%0d", g), gids[g], 0);
`endif
    end

    // Single access, chipset idle.
    addr = {23'h0ABCDE, 23'h001234};
    uds = 2'b01; lds = 2'b01; req = 2'b01;
    wait_cs(ok);
    chk("A_addr", ram_addr, 23'h001234);
    chk("A_bytes", {ram_uds, ram_lds}, 2'b11);
    chk("A_gid", grant_id, 0);
    wait_ready(ok, w);
    chk("A_ready", ready, 2'b01);
    chk("A_cs_low", ram_cs, 0);
    chk("A_min_hold", w >= LAT + 1, 1);
    req = '0;
    @(negedge clk_sys);
    chk("A_ready_1cyc", ready, 0);

    // Chipset busy for two retries.
    chip_idle = 1'b0; req = 2'b01;
    wait_cs(ok);
    repeat (2) @(negedge clk_sys);
    att = 0; got = 0;
    for (int k = 0; k < 80 && !got; k++) begin
      if (ready != '0) begin
        got = 1;
        chk("B_attempts", att, 3);
        chk("B_ready", ready, 2'b01);
      end else begin
        if (att == 2) chip_idle = 1'b1;
        chk("B_cs_held", ram_cs, 1);
        if (clk7_en) att++;
        @(negedge clk_sys);
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL B_timeout: no ready, required pulse");
    end
    req = '0; chip_idle = 1'b1;

    // Winner drops its request mid-access.
    addr[AW-1:0] = 23'h055AA5; req = 2'b01;
    wait_cs(ok);
    @(negedge clk_sys);
    req = '0;
    @(negedge clk_sys);
    chk("D_cs_low", ram_cs, 0);
    chk("D_ready", ready, 0);
    repeat (6) begin
      @(negedge clk_sys);
      chk("D_no_ready", ready, 0);
    end

    // Reset in the middle of an access.
    addr[AW-1:0] = 23'h00BEEF; req = 2'b01;
    wait_cs(ok);
    @(negedge clk_sys);
    #1 reset = 1'b1;
    #1;
    chk("E_cs", ram_cs, 0);
    chk("E_ready", ready, 0);
    chk("E_addr", ram_addr, 0);
    chk("E_gid", grant_id, 0);
    chk("E_bytes", {ram_uds, ram_lds}, 0);
    chk("E_ph", {ph1, ph2}, 0);
    chk("E_rs", reset_sync, 0);
    @(posedge clk_sys);
    #2 reset = 1'b0;
    for (int k = 0; k < 20 && !reset_sync; k++) begin
      @(negedge clk_sys);
      chk("E_hold_cs", ram_cs, 0);
      chk("E_hold_ready", ready, 0);
    end
    wait_cs(ok);
    chk("E_addr2", ram_addr, 23'h00BEEF);
    wait_ready(ok, w);
    chk("E_ready2", ready, 2'b01);
    req = '0;
    repeat (4) @(negedge clk_sys);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/turbo_ram_arb.md
TURBO_RAM_ARB -- requirements
Module: turbo_ram_arb

Interface
REQ-001 SHALL provide parameter NCH, default 2, number of requesting bus masters (1..8).
REQ-002 SHALL provide parameter AW, default 23, word address width per channel.
REQ-003 SHALL provide parameter LAT, default 2, minimum clk_sys cycles ram_cs is held before ready may issue (0..15).
REQ-004 SHALL provide parameter RST_STAGES, default 8, reset-release synchroniser depth (2..16).
REQ-005 SHALL provide ports:
 clk_sys  in  1  system clock (28 MHz domain)
 reset  in  1  asynchronous, active-high reset
 c1, c3  in  1  chipset phase signals
 clk7_en  in  1  7 MHz clock enable
 chip_idle  in  1  chipset not using RAM this slot (high = free)
 req  in  NCH  per-channel access request, level
 addr  in  NCH*AW  per-channel address, channel i at bits [i*AW +: AW]
 uds, lds  in  NCH  per-channel byte selects, active-high
 ph1, ph2  out  1  registered CPU phase strobes
 ram_cs  out  1  turbo RAM chip select
 ram_addr  out  AW  latched address of granted channel
 ram_uds, ram_lds  out  1  latched byte selects
 ready  out  NCH  one-cycle completion pulse, one-hot
 grant_id  out  max(1,clog2(NCH))  index of granted channel
 reset_sync  out  1  synchronised active-high run indication

Function
REQ-006 ph1 SHALL register c1&c3, ph2 SHALL register !c1&!c3, each clk_sys edge; both forced 0 while reset_sync=0.
REQ-007 FSM SHALL have states IDLE and ACCESS only.
REQ-008 IDLE: on a cycle with ph2=1 and any req bit set, SHALL select a winner, latch its addr/uds/lds into ram_addr/ram_uds/ram_lds, set grant_id, assert ram_cs, load counter with LAT and enter ACCESS; ram_cs is high on the next cycle (1-cycle latency from ph2 sample).
REQ-009 req arriving while ph2=0 SHALL wait in IDLE for the next ph2.
REQ-010 ACCESS: counter SHALL decrement by 1 per cycle, saturating at 0; ram_cs, ram_addr, ram_uds, ram_lds, grant_id held stable.
REQ-011 ACCESS with counter=0, clk7_en=1, chip_idle=1: SHALL pulse ready[grant_id] for exactly one cycle, deassert ram_cs the same cycle, return to IDLE.
REQ-012 ACCESS with counter=0, clk7_en=1, chip_idle=0: SHALL stay in ACCESS with ram_cs held and retry at each following clk7_en; no ready.
REQ-013 clk7_en while counter>0 SHALL be ignored.
REQ-014 Winner's req dropping during ACCESS SHALL abort: ram_cs low and IDLE next cycle, no ready; other channels' req changes ignored.
REQ-015 IDLE re-grant SHALL not occur in the cycle that ready is pulsed; earliest next grant is the following ph2.
REQ-016 Arbitration without the macro SHALL be fixed priority, lowest index wins.
REQ-017 ready SHALL never have more than one bit set; ram_cs=0 implies ready=0 on the next cycle.

Reset
REQ-018 reset=1 SHALL immediately force FSM=IDLE, counter=0, ph1=ph2=ram_cs=0, ram_addr=0, ram_uds=ram_lds=0, ready=0, grant_id=0, RR pointer=0, reset_sync=0, including mid-ACCESS.
REQ-019 After reset falls, a RST_STAGES-deep shift register SHALL assert reset_sync exactly RST_STAGES+1 clk_sys edges later; no grant before reset_sync=1.

Configuration
REQ-020 Macro TURBO_ARB_ROUND_ROBIN_EN defined: SHALL use round-robin; search starts at pointer, pointer becomes winner+1 mod NCH on each grant (not on abort).
REQ-021 TURBO_ARB_ROUND_ROBIN_EN undefined: SHALL use fixed priority per REQ-016 and contain no pointer register.

Verification
REQ-022 Reset release, RST_STAGES=8 -> reset_sync rises on 9th edge; ph1/ph2 stay 0 until then.
REQ-023 NCH=2, LAT=2, req[0]=1 addr=0x001234 uds=lds=1, chip_idle=1 -> ram_cs high cycle after ph2, ram_addr=0x001234, ready=2'b01 at first clk7_en with counter=0, single cycle.
REQ-024 Same with chip_idle=0 for two clk7_en then 1 -> ram_cs held throughout, ready pulses on third clk7_en only.
REQ-025 req=2'b11 continuously, four grants -> fixed mode grant_id 0,0,0,0; with TURBO_ARB_ROUND_ROBIN_EN grant_id 0,1,0,1.
REQ-026 req[0] dropped two cycles into ACCESS -> ram_cs low next cycle, ready stays 0, RR pointer unchanged.
REQ-027 reset pulsed mid-ACCESS -> all outputs 0 same cycle; no ready until new grant after reset_sync=1.
